// File: rtl/tpx3_shutter_seq_if.sv
// Timepix3 shutter sequencer bus: host command/config in, chip strobes and status out.
interface tpx3_shutter_seq_if #(
    parameter int CNT_W = 32,
    parameter int TP_W  = 16
);
    logic             START;
    logic             STOP;
    logic [TP_W-1:0]  CONF_DELAY;
    logic [CNT_W-1:0] CONF_WIDTH;
    logic [TP_W-1:0]  CONF_TP_NUM;
    logic [TP_W-1:0]  CONF_TP_HIGH;
    logic [TP_W-1:0]  CONF_TP_LOW;
    logic [TP_W-1:0]  CONF_REPEAT;
    logic             CONF_EN_T0;
    logic             Shutter;
    logic             ExtTPulse;
    logic             T0_Sync;
    logic             BUSY;
    logic             DONE;
    logic [TP_W-1:0]  FRAME_CNT;

    modport master (
        output START, STOP, CONF_DELAY, CONF_WIDTH, CONF_TP_NUM, CONF_TP_HIGH,
               CONF_TP_LOW, CONF_REPEAT, CONF_EN_T0,
        input  Shutter, ExtTPulse, T0_Sync, BUSY, DONE, FRAME_CNT
    );

    modport slave (
        input  START, STOP, CONF_DELAY, CONF_WIDTH, CONF_TP_NUM, CONF_TP_HIGH,
               CONF_TP_LOW, CONF_REPEAT, CONF_EN_T0,
        output Shutter, ExtTPulse, T0_Sync, BUSY, DONE, FRAME_CNT
    );
endinterface

// File: rtl/tpx3_shutter_seq.sv
// Timepix3 shutter / test-pulse frame sequencer (CLK40 domain).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for START, outputs low
// S_T0    | one cycle after acceptance, T0_Sync strobe if enabled
// S_DELAY | Shutter low for the programmed pre-shutter delay
// S_OPEN  | Shutter high, ExtTPulse burst running
// S_DONE  | one-cycle DONE pulse, then back to idle
//
// Frames of zero total length (delay=0, width=0) complete instantly, so a
// finite run of them jumps straight from S_T0 to S_DONE with the full count.
module tpx3_shutter_seq #(
    parameter int CNT_W = 32,
    parameter int TP_W  = 16
) (
    input  logic              CLK40,
    input  logic              RST,
    tpx3_shutter_seq_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_T0, S_DELAY, S_OPEN, S_DONE} state_t;
    typedef enum logic [1:0] {TP_IDLE, TP_HIGH, TP_LOW} tp_state_t;

    localparam logic [TP_W-1:0]  TP_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [TP_W:0]    INC_ONE = 1;

    state_t           r_state,    w_state_nxt;
    tp_state_t        r_tp_state, w_tp_state_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [TP_W-1:0]  r_frame_cnt, w_frame_nxt;
    logic [TP_W-1:0]  r_tp_cnt,   w_tp_cnt_nxt;
    logic [TP_W-1:0]  r_tp_left,  w_tp_left_nxt;

    logic [TP_W-1:0]  r_delay, r_tp_num, r_tp_high, r_tp_low, r_repeat;
    logic [CNT_W-1:0] r_width;

    logic r_shutter, r_ext, r_t0, r_busy, r_done;

    logic            w_load_cfg, w_frame_end, w_frame_start, w_tp_start, w_stop;
    logic [TP_W:0]   w_frame_inc;

    // Next-state, counter and pulse-engine decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_frame_nxt    = r_frame_cnt;
        w_tp_state_nxt = r_tp_state;
        w_tp_cnt_nxt   = r_tp_cnt;
        w_tp_left_nxt  = r_tp_left;
        w_load_cfg     = 1'b0;
        w_frame_end    = 1'b0;
        w_frame_start  = 1'b0;
        w_tp_start     = 1'b0;
        w_frame_inc    = {1'b0, r_frame_cnt} + INC_ONE;
        w_stop         = bus.STOP && (r_state == S_T0 || r_state == S_DELAY || r_state == S_OPEN);

        case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    w_load_cfg  = 1'b1;
                    w_state_nxt = S_T0;
                    w_frame_nxt = '0;
                end
            end
            S_T0: w_frame_start = 1'b1;
            S_DELAY: begin
                if (r_cnt == '0) begin
                    if (r_width == '0) begin
                        w_frame_end = 1'b1;
                    end else begin
                        w_state_nxt = S_OPEN;
                        w_cnt_nxt   = r_width - CNT_ONE;
                        w_tp_start  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_OPEN: begin
                case (r_tp_state)
                    TP_HIGH: begin
                        if (r_tp_cnt == '0) begin
                            if (r_tp_left == '0) begin
                                w_tp_state_nxt = TP_IDLE;
                            end else if (r_tp_low == '0) begin
                                w_tp_cnt_nxt  = r_tp_high - TP_ONE;
                                w_tp_left_nxt = r_tp_left - TP_ONE;
                            end else begin
                                w_tp_state_nxt = TP_LOW;
                                w_tp_cnt_nxt   = r_tp_low - TP_ONE;
                            end
                        end else begin
                            w_tp_cnt_nxt = r_tp_cnt - TP_ONE;
                        end
                    end
                    TP_LOW: begin
                        if (r_tp_cnt == '0) begin
                            w_tp_state_nxt = TP_HIGH;
                            w_tp_cnt_nxt   = r_tp_high - TP_ONE;
                            w_tp_left_nxt  = r_tp_left - TP_ONE;
                        end else begin
                            w_tp_cnt_nxt = r_tp_cnt - TP_ONE;
                        end
                    end
                    default: w_tp_state_nxt = TP_IDLE;
                endcase
                if (r_cnt == '0) w_frame_end = 1'b1;
                else             w_cnt_nxt   = r_cnt - CNT_ONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_frame_end) begin
            w_frame_nxt = (&r_frame_cnt) ? r_frame_cnt : w_frame_inc[TP_W-1:0];
            if (r_repeat == '0 || w_frame_inc < {1'b0, r_repeat}) w_frame_start = 1'b1;
            else                                                  w_state_nxt   = S_DONE;
        end

        if (w_frame_start) begin
            if (r_delay != '0) begin
                w_state_nxt = S_DELAY;
                w_cnt_nxt   = CNT_W'(r_delay) - CNT_ONE;
            end else if (r_width != '0) begin
                w_state_nxt = S_OPEN;
                w_cnt_nxt   = r_width - CNT_ONE;
                w_tp_start  = 1'b1;
            end else if (r_repeat != '0) begin
                w_state_nxt = S_DONE;
                w_frame_nxt = r_repeat;
            end else begin
                // endless run of empty frames: count one per cycle until STOP
                w_state_nxt = S_DELAY;
                w_cnt_nxt   = '0;
            end
        end

        if (w_tp_start) begin
            if (r_tp_num != '0 && r_tp_high != '0) begin
                w_tp_state_nxt = TP_HIGH;
                w_tp_cnt_nxt   = r_tp_high - TP_ONE;
                w_tp_left_nxt  = r_tp_num - TP_ONE;
            end else begin
                w_tp_state_nxt = TP_IDLE;
            end
        end

        if (w_stop) begin
            w_state_nxt = S_DONE;
            w_frame_nxt = r_frame_cnt;
        end

        if (w_state_nxt != S_OPEN) w_tp_state_nxt = TP_IDLE;
    end

    // Sequencer state, timers and frame counter.
    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_tp_state  <= TP_IDLE;
            r_cnt       <= '0;
            r_frame_cnt <= '0;
            r_tp_cnt    <= '0;
            r_tp_left   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tp_state  <= w_tp_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_tp_cnt    <= w_tp_cnt_nxt;
            r_tp_left   <= w_tp_left_nxt;
        end
    end

    // Config snapshot at START acceptance and registered chip/status outputs.
    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            r_delay   <= '0;
            r_width   <= '0;
            r_tp_num  <= '0;
            r_tp_high <= '0;
            r_tp_low  <= '0;
            r_repeat  <= '0;
            r_shutter <= 1'b0;
            r_ext     <= 1'b0;
            r_t0      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_load_cfg) begin
                r_delay   <= bus.CONF_DELAY;
                r_width   <= bus.CONF_WIDTH;
                r_tp_num  <= bus.CONF_TP_NUM;
                r_tp_high <= bus.CONF_TP_HIGH;
                r_tp_low  <= bus.CONF_TP_LOW;
                r_repeat  <= bus.CONF_REPEAT;
            end
            r_shutter <= (w_state_nxt == S_OPEN);
            r_ext     <= (w_state_nxt == S_OPEN) && (w_tp_state_nxt == TP_HIGH);
            r_t0      <= w_load_cfg && bus.CONF_EN_T0;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.Shutter   = r_shutter;
    assign bus.ExtTPulse = r_ext;
    assign bus.T0_Sync   = r_t0;
    assign bus.BUSY      = r_busy;
    assign bus.DONE      = r_done;
    assign bus.FRAME_CNT = r_frame_cnt;
endmodule

// File: tb/tb_tpx3_shutter_seq.sv
// Bench for tpx3_shutter_seq: per-cycle trace compared against a frame-level model.
module tb_tpx3_shutter_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // packed sample: {BUSY, DONE, Shutter, ExtTPulse, T0_Sync, FRAME_CNT[15:0]}
    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];

    tpx3_shutter_seq_if bus();
    tpx3_shutter_seq dut (.CLK40(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [20:0] pk(input bit b, input bit dn, input bit s, input bit e,
                                       input bit t0, input int fc);
        logic [31:0] f;
        f = fc;
        return {b, dn, s, e, t0, f[15:0]};
    endfunction

    // Expected trace from cycle k+1: T0 cycle, R frames of D low + W high cycles, DONE, 3 idle.
    function automatic void build_model(input int d, input int w, input int n, input int h,
                                        input int l, input int r, input bit en, input int stop_at);
        int fc;
        int sfc;
        bit e;
        fc = 0;
        exp_q.delete();
        exp_q.push_back(pk(1, 0, 0, 0, en, 0));
        for (int f = 0; f < ((r == 0) ? 1000 : r); f++) begin
            if (r == 0 && exp_q.size() > stop_at + 1) break;
            for (int j = 0; j < d; j++) exp_q.push_back(pk(1, 0, 0, 0, 0, fc));
            for (int j = 0; j < w; j++) begin
                e = (h > 0) && ((j / (h + l)) < n) && ((j % (h + l)) < h);
                exp_q.push_back(pk(1, 0, 1, e, 0, fc));
            end
            if (fc < 65535) fc++;
        end
        exp_q.push_back(pk(1, 1, 0, 0, 0, fc));
        if (stop_at > 0 && stop_at < exp_q.size()) begin
            sfc = int'(exp_q[stop_at-1][15:0]);
            while (exp_q.size() > stop_at) void'(exp_q.pop_back());
            exp_q.push_back(pk(1, 1, 0, 0, 0, sfc));
            fc = sfc;
        end
        repeat (3) exp_q.push_back(pk(0, 0, 0, 0, 0, fc));
    endfunction

    task automatic set_conf(input int d, input int w, input int n, input int h,
                            input int l, input int r, input bit en);
        bus.CONF_DELAY   = 16'(d);
        bus.CONF_WIDTH   = 32'(w);
        bus.CONF_TP_NUM  = 16'(n);
        bus.CONF_TP_HIGH = 16'(h);
        bus.CONF_TP_LOW  = 16'(l);
        bus.CONF_REPEAT  = 16'(r);
        bus.CONF_EN_T0   = en;
    endtask

    // START at edge k, then record n cycles (k+1..k+n) sampled on the falling edge.
    task automatic launch(input int n, input int start2_at, input int stop_at, input bit scramble);
        obs_q.delete();
        @(negedge clk);
        bus.START = 1'b1;
        for (int t = 1; t <= n; t++) begin
            @(negedge clk);
            obs_q.push_back({bus.BUSY, bus.DONE, bus.Shutter, bus.ExtTPulse, bus.T0_Sync, bus.FRAME_CNT});
            bus.START = (t == start2_at);
            bus.STOP  = (t == stop_at);
            if (scramble) begin
                bus.CONF_DELAY   = 16'($urandom);
                bus.CONF_WIDTH   = $urandom;
                bus.CONF_TP_NUM  = 16'($urandom);
                bus.CONF_TP_HIGH = 16'($urandom);
                bus.CONF_TP_LOW  = 16'($urandom);
                bus.CONF_REPEAT  = 16'($urandom);
                bus.CONF_EN_T0   = 1'($urandom);
            end
        end
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
    endtask

    task automatic test_reset;
        logic [20:0] got;
        rst = 1'b1;
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        set_conf(0, 0, 0, 0, 0, 0, 0);
        #23;
        got = {bus.BUSY, bus.DONE, bus.Shutter, bus.ExtTPulse, bus.T0_Sync, bus.FRAME_CNT};
        checks++;
        if (got !== 21'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, 21'h0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_frame;
        set_conf(5, 20, 3, 2, 3, 1, 1);
        build_model(5, 20, 3, 2, 3, 1, 1, 0);
        launch(exp_q.size(), 0, 0, 0);
        for (int t = 0; t < exp_q.size(); t++) begin
            checks++;
            if (obs_q[t] !== exp_q[t]) begin
                errors++;
                $display("FAIL single_frame k+%0d: got %h expected %h", t + 1, obs_q[t], exp_q[t]);
            end
        end
        // t0@k+1, t0@k+2, sh@k+6, sh@k+7, sh@k+26, sh@k+27, ext@k+11, ext@k+12, done@k+27
        checks++;
        if ({obs_q[0][16], obs_q[1][16], obs_q[5][18], obs_q[6][18], obs_q[25][18],
             obs_q[26][18], obs_q[10][17], obs_q[11][17], obs_q[26][19]} !== 9'b100110011) begin
            errors++;
            $display("FAIL single_frame_edges: got %b expected %b",
                     {obs_q[0][16], obs_q[1][16], obs_q[5][18], obs_q[6][18], obs_q[25][18],
                      obs_q[26][18], obs_q[10][17], obs_q[11][17], obs_q[26][19]}, 9'b100110011);
        end
        checks++;
        if (obs_q[26][15:0] !== 16'd1) begin
            errors++;
            $display("FAIL single_frame_cnt: got %0d expected 1", obs_q[26][15:0]);
        end
    endtask

    task automatic test_repeat;
        int n_t0;
        int n_sh;
        set_conf(2, 4, 0, 1, 1, 3, 1);
        build_model(2, 4, 0, 1, 1, 3, 1, 0);
        launch(exp_q.size(), 0, 0, 0);
        n_t0 = 0;
        n_sh = 0;
        for (int t = 0; t < exp_q.size(); t++) begin
            n_t0 += int'(obs_q[t][16]);
            n_sh += int'(obs_q[t][18]);
            checks++;
            if (obs_q[t] !== exp_q[t]) begin
                errors++;
                $display("FAIL repeat k+%0d: got %h expected %h", t + 1, obs_q[t], exp_q[t]);
            end
        end
        checks++;
        if (n_t0 != 1 || n_sh != 12 || obs_q[19][15:0] !== 16'd3 || obs_q[19][19] !== 1'b1) begin
            errors++;
            $display("FAIL repeat_summary: got t0=%0d sh=%0d cnt=%0d done=%b expected 1 12 3 1",
                     n_t0, n_sh, obs_q[19][15:0], obs_q[19][19]);
        end
    endtask

    task automatic test_truncation;
        int n_ext;
        set_conf(1, 6, 4, 2, 2, 1, 0);
        build_model(1, 6, 4, 2, 2, 1, 0, 0);
        launch(exp_q.size(), 0, 0, 0);
        n_ext = 0;
        for (int t = 0; t < exp_q.size(); t++) begin
            n_ext += int'(obs_q[t][17]);
            checks++;
            if (obs_q[t] !== exp_q[t]) begin
                errors++;
                $display("FAIL truncation k+%0d: got %h expected %h", t + 1, obs_q[t], exp_q[t]);
            end
        end
        checks++;
        if (n_ext != 4) begin
            errors++;
            $display("FAIL truncation_ext_cycles: got %0d expected 4", n_ext);
        end
    endtask

    task automatic test_stop;
        // D=3, W=5: third frame OPEN spans k+21..k+25; STOP sampled at end of k+23
        set_conf(3, 5, 2, 1, 1, 0, 1);
        build_model(3, 5, 2, 1, 1, 0, 1, 23);
        launch(exp_q.size(), 0, 23, 0);
        for (int t = 0; t < exp_q.size(); t++) begin
            checks++;
            if (obs_q[t] !== exp_q[t]) begin
                errors++;
                $display("FAIL stop k+%0d: got %h expected %h", t + 1, obs_q[t], exp_q[t]);
            end
        end
        checks++;
        if ({obs_q[22][18], obs_q[23][18], obs_q[23][19], obs_q[24][20]} !== 4'b1010 ||
            obs_q[23][15:0] !== 16'd2) begin
            errors++;
            $display("FAIL stop_edges: got sh=%b%b done=%b busy=%b cnt=%0d expected 10 1 0 2",
                     obs_q[22][18], obs_q[23][18], obs_q[23][19], obs_q[24][20], obs_q[23][15:0]);
        end
    endtask

    task automatic test_corners;
        int run_len;
        // empty frames: DONE one cycle after T0 with both frames counted
        set_conf(0, 0, 2, 1, 1, 2, 0);
        build_model(0, 0, 2, 1, 1, 2, 0, 0);
        launch(exp_q.size(), 0, 0, 0);
        for (int t = 0; t < exp_q.size(); t++) begin
            checks++;
            if (obs_q[t] !== exp_q[t]) begin
                errors++;
                $display("FAIL empty_frames k+%0d: got %h expected %h", t + 1, obs_q[t], exp_q[t]);
            end
        end
        checks++;
        if (obs_q[1][19] !== 1'b1 || obs_q[1][15:0] !== 16'd2) begin
            errors++;
            $display("FAIL empty_frames_done: got done=%b cnt=%0d expected 1 2", obs_q[1][19], obs_q[1][15:0]);
        end
        // START mid-run with config churning every cycle: no effect
        set_conf(0, 3, 1, 1, 0, 2, 1);
        build_model(0, 3, 1, 1, 0, 2, 1, 0);
        launch(exp_q.size(), 4, 0, 1);
        for (int t = 0; t < exp_q.size(); t++) begin
            checks++;
            if (obs_q[t] !== exp_q[t]) begin
                errors++;
                $display("FAIL busy_start k+%0d: got %h expected %h", t + 1, obs_q[t], exp_q[t]);
            end
        end
        // START presented during the DONE cycle is ignored
        set_conf(1, 2, 0, 0, 0, 1, 0);
        build_model(1, 2, 0, 0, 0, 1, 0, 0);
        run_len = exp_q.size() - 3;
        launch(exp_q.size(), run_len, 0, 0);
        for (int t = 0; t < exp_q.size(); t++) begin
            checks++;
            if (obs_q[t] !== exp_q[t]) begin
                errors++;
                $display("FAIL done_start k+%0d: got %h expected %h", t + 1, obs_q[t], exp_q[t]);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        logic [20:0] got;
        set_conf(0, 5, 2, 1, 1, 3, 1);
        launch(8, 0, 0, 0);
        checks++;
        if (obs_q[7][18] !== 1'b1 || obs_q[7][15:0] !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset: got sh=%b cnt=%0d expected 1 1", obs_q[7][18], obs_q[7][15:0]);
        end
        rst = 1'b1;
        #2;
        got = {bus.BUSY, bus.DONE, bus.Shutter, bus.ExtTPulse, bus.T0_Sync, bus.FRAME_CNT};
        checks++;
        if (got !== 21'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", got, 21'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        int d, w, n, h, l, r, stop_at, s2, run_len;
        bit en, scr;
        for (int it = 0; it < 24; it++) begin
            d   = $urandom_range(0, 4);
            w   = $urandom_range(0, 10);
            n   = $urandom_range(0, 4);
            h   = $urandom_range(0, 3);
            l   = $urandom_range(0, 3);
            r   = $urandom_range(1, 3);
            en  = 1'($urandom);
            scr = 1'($urandom);
            set_conf(d, w, n, h, l, r, en);
            build_model(d, w, n, h, l, r, en, 0);
            run_len = exp_q.size() - 3;
            stop_at = ($urandom_range(0, 2) == 0 && run_len > 1) ? $urandom_range(1, run_len - 1) : 0;
            build_model(d, w, n, h, l, r, en, stop_at);
            run_len = exp_q.size() - 3;
            s2 = $urandom_range(0, run_len);
            launch(exp_q.size(), s2, stop_at, scr);
            for (int t = 0; t < exp_q.size(); t++) begin
                checks++;
                if (obs_q[t] !== exp_q[t]) begin
                    errors++;
                    $display("FAIL random it%0d k+%0d (d=%0d w=%0d n=%0d h=%0d l=%0d r=%0d stop=%0d): got %h expected %h",
                             it, t + 1, d, w, n, h, l, r, stop_at, obs_q[t], exp_q[t]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_repeat;
        test_truncation;
        test_stop;
        test_corners;
        test_reset_mid_run;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
